mem_responder: RTL and testbench

- Word-wide memory responder: the slave end of the CPU memory interface.
- Serves CPU reads with the `rd_en`/`rd_valid` request–response handshake, after a configurable latency.
- Performs single-cycle word writes on `wr_en`.
- Sits directly on the CPU bus. It backs the program image, the vector words at 0x0080/0x0084 and the memory-mapped register file at 0x0000–0x007C.

---
 rtl/mem_responder.sv | 134 +++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-wide CPU memory slave with fixed-latency reads and single-cycle writes.
// Reads use a level rd_en / one-cycle rd_valid handshake; writes run independently of the read FSM.
module mem_responder #(
  parameter int    ADDR_W    = 16,
  parameter int    MEM_WORDS = 4096,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  output logic              oob
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             oob_q, oob_d;

  logic [31:0]      mem_q [MEM_WORDS];

  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic             idx_ok_s;
  logic             rd_ok_s;
  logic             wr_fire_s;
  logic             fwd_s;
  logic [31:0]      rd_word_s;
  logic             unused_s;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(MEM_WORDS);
  endfunction

  assign idx_s     = i_addr[ADDR_W-1:2];
  assign idx_ok_s  = in_range(idx_s);
  assign wr_fire_s = wr_en && idx_ok_s;
  assign rd_idx_s  = (state_q == ST_IDLE) ? idx_s : addr_q;
  assign rd_ok_s   = in_range(rd_idx_s);
  // A write landing on the same edge that registers rd_data wins (write-first).
  assign fwd_s     = wr_fire_s && (idx_s == rd_idx_s);
  assign rd_word_s = !rd_ok_s ? 32'd0 : (fwd_s ? wr_data : mem_q[rd_idx_s[MEM_AW-1:0]]);
  assign unused_s  = ^i_addr[1:0];

  // Word write port: no reset on the array, writes are dropped while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && wr_fire_s) begin
      mem_q[idx_s[MEM_AW-1:0]] <= wr_data;
    end
  end

  // Read FSM next-state, latency counter and registered response values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    oob_d      = !idx_ok_s && (wr_en || ((state_q == ST_IDLE) && rd_en));
    case (state_q)
      ST_IDLE: begin
        if (rd_en) begin
          addr_d = idx_s;
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            rd_valid_d = 1'b1;
            rd_data_d  = rd_word_s;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = ST_RESP;
          rd_valid_d = 1'b1;
          rd_data_d  = rd_word_s;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      oob_q      <= oob_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign oob      = oob_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with LATENCY 1, 3 and 4 share one clock.
module tb_mem_responder;

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic             clk = 1'b0;
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  exp_t             sb_q[$];

  logic [2:0]       rst_n;
  logic [2:0]       rd_en;
  logic [2:0]       wr_en;
  logic [2:0][15:0] addr;
  logic [2:0][31:0] wr_data;
  wire  [2:0]       rd_valid;
  wire  [2:0]       oob;
  wire  [2:0][31:0] rd_data;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_W   (16),
      .MEM_WORDS(4096),
      .LATENCY  ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .INIT_FILE("")
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .rd_en   (rd_en[g]),
      .i_addr  (addr[g]),
      .rd_data (rd_data[g]),
      .rd_valid(rd_valid[g]),
      .wr_en   (wr_en[g]),
      .wr_data (wr_data[g]),
      .oob     (oob[g])
    );
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input int c, input logic [31:0] data);
    exp_t e;
    e.dut  = d;
    e.cyc  = c;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic do_write(input int d, input logic [15:0] a, input logic [31:0] data, input logic exp_oob);
    wr_en[d]   = 1'b1;
    addr[d]    = a;
    wr_data[d] = data;
    tick();
    wr_en[d] = 1'b0;
    check_value($sformatf("oob_wr_d%0d", d), 32'(oob[d]), 32'(exp_oob));
  endtask

  // Wait (bounded) for the response, then drop rd_en as the CPU would and move past RESP.
  task automatic wait_valid(input int d, input logic toggle);
    int n = 0;
    while (rd_valid[d] !== 1'b1 && n < 40) begin
      if (toggle) addr[d] = addr[d] ^ 16'h0ff0;
      @(negedge clk);
      n++;
    end
    if (rd_valid[d] !== 1'b1) check_value($sformatf("rd_timeout_d%0d", d), 32'(rd_valid[d]), 32'd1);
    rd_en[d] = 1'b0;
    tick();
  endtask

  task automatic do_read(input int d, input logic [15:0] a, input logic [31:0] exp, input int lat,
                         input logic exp_oob, input logic toggle);
    rd_en[d] = 1'b1;
    addr[d]  = a;
    push_exp(d, cyc + lat, exp);
    @(negedge clk);
    @(negedge clk);
    check_value($sformatf("oob_rd_d%0d", d), 32'(oob[d]), 32'(exp_oob));
    wait_valid(d, toggle);
  endtask

  // Scoreboard: every rd_valid cycle must match the oldest expected response for that instance.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rd_valid[d] === 1'b1) begin
        if (sb_q.size() > 0 && sb_q[0].dut == d) begin
          e = sb_q.pop_front();
          check_value($sformatf("rd_data_d%0d", d), rd_data[d], e.data);
          check_value($sformatf("rd_cycle_d%0d", d), 32'(cyc), 32'(e.cyc));
        end else begin
          check_value($sformatf("spurious_valid_d%0d", d), 32'(rd_valid[d]), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 3'b000;
    rd_en   = 3'b000;
    wr_en   = 3'b000;
    addr    = '0;
    wr_data = '0;
    repeat (2) tick();
    rst_n = 3'b111;
    tick();
    for (int d = 0; d < 3; d++) begin
      check_value("reset_valid", 32'(rd_valid[d]), 32'd0);
      check_value("reset_data", rd_data[d], 32'd0);
      check_value("reset_oob", 32'(oob[d]), 32'd0);
    end

    // Reset holds off reads and writes
    do_write(0, 16'h0010, 32'hA5A5_0004, 1'b0);
    rst_n[0]   = 1'b0;
    rd_en[0]   = 1'b1;
    wr_en[0]   = 1'b1;
    addr[0]    = 16'h0010;
    wr_data[0] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value("rst_hold_valid", 32'(rd_valid[0]), 32'd0);
      check_value("rst_hold_data", rd_data[0], 32'd0);
      check_value("rst_hold_oob", 32'(oob[0]), 32'd0);
    end
    rst_n[0] = 1'b1;
    rd_en[0] = 1'b0;
    wr_en[0] = 1'b0;
    tick();
    do_read(0, 16'h0010, 32'hA5A5_0004, 1, 1'b0, 1'b0);

    // Write then read at LATENCY=1, low address bits ignored, data held afterwards
    do_write(0, 16'h0084, 32'hDEAD_BEEF, 1'b0);
    do_read(0, 16'h0086, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
    tick();
    tick();
    check_value("rd_data_hold", rd_data[0], 32'hDEAD_BEEF);
    check_value("valid_low_after", 32'(rd_valid[0]), 32'd0);

    // Same-edge write and read at LATENCY=1 returns the written word
    rd_en[0]   = 1'b1;
    wr_en[0]   = 1'b1;
    addr[0]    = 16'h0088;
    wr_data[0] = 32'h4444_4444;
    push_exp(0, cyc + 1, 32'h4444_4444);
    tick();
    wr_en[0] = 1'b0;
    rd_en[0] = 1'b0;
    tick();
    do_read(0, 16'h0088, 32'h4444_4444, 1, 1'b0, 1'b0);

    // LATENCY=3 back-to-back CPU-style reads with i_addr toggled during WAIT
    do_write(1, 16'h0000, 32'd1, 1'b0);
    do_write(1, 16'h0004, 32'd2, 1'b0);
    do_write(1, 16'h0008, 32'd3, 1'b0);
    do_read(1, 16'h0000, 32'd1, 3, 1'b0, 1'b1);
    do_read(1, 16'h0004, 32'd2, 3, 1'b0, 1'b1);
    do_read(1, 16'h0008, 32'd3, 3, 1'b0, 1'b1);

    // Out-of-range accesses and the top in-range word
    do_write(0, 16'h0000, 32'h0BAD_F00D, 1'b0);
    do_write(0, 16'h4000, 32'h1234_5678, 1'b1);
    do_read(0, 16'h0000, 32'h0BAD_F00D, 1, 1'b0, 1'b0);
    do_read(0, 16'h4000, 32'h0000_0000, 1, 1'b1, 1'b0);
    do_write(0, 16'h3FFC, 32'hCAFE_F00D, 1'b0);
    do_read(0, 16'h3FFE, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    rd_en[0]   = 1'b1;
    wr_en[0]   = 1'b1;
    addr[0]    = 16'hFFFC;
    wr_data[0] = 32'h9999_9999;
    push_exp(0, cyc + 1, 32'h0000_0000);
    tick();
    wr_en[0] = 1'b0;
    rd_en[0] = 1'b0;
    check_value("oob_both_high", 32'(oob[0]), 32'd1);
    tick();
    check_value("oob_both_single", 32'(oob[0]), 32'd0);

    // Reset in the middle of a LATENCY=4 read
    do_write(2, 16'h0040, 32'h5555_AAAA, 1'b0);
    do_read(2, 16'h0040, 32'h5555_AAAA, 4, 1'b0, 1'b0);
    rd_en[2] = 1'b1;
    addr[2]  = 16'h0040;
    tick();
    tick();
    rst_n[2] = 1'b0;
    tick();
    rst_n[2] = 1'b1;
    rd_en[2] = 1'b0;
    check_value("midrst_data", rd_data[2], 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_value("midrst_valid", 32'(rd_valid[2]), 32'd0);
      tick();
    end
    do_read(2, 16'h0040, 32'h5555_AAAA, 4, 1'b0, 1'b0);

    // Writes while a LATENCY=3 read is pending
    do_write(1, 16'h0020, 32'h0000_0011, 1'b0);
    rd_en[1] = 1'b1;
    addr[1]  = 16'h0020;
    push_exp(1, cyc + 3, 32'h0000_0022);
    tick();
    wr_en[1]   = 1'b1;
    wr_data[1] = 32'h0000_0022;
    tick();
    wr_en[1] = 1'b0;
    wait_valid(1, 1'b0);
    rd_en[1] = 1'b1;
    push_exp(1, cyc + 3, 32'h0000_0033);
    tick();
    tick();
    wr_en[1]   = 1'b1;
    wr_data[1] = 32'h0000_0033;
    tick();
    wr_en[1] = 1'b0;
    wait_valid(1, 1'b0);

    tick();
    check_value("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
